// File: rtl/uart_dbg_pkg.sv
// Shared types, ASCII constants and character helpers for the UART debug bridge.
package uart_dbg_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_SEP, S_DATA, S_TAIL, S_CNT, S_RCMD, S_ERR,
    S_RD_REQ, S_RD_CAP, S_RD_TX, S_WR_REQ, S_SEND, S_RST_TX, S_RST_PULSE
  } state_e;

  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_TAB  = 8'h09;
  localparam logic [7:0] CH_CR   = 8'h0d;
  localparam logic [7:0] CH_LF   = 8'h0a;
  localparam logic [7:0] CH_R    = 8'h72;
  localparam logic [7:0] CH_STAR = 8'h2a;

  // Fixed responses, left-aligned; the serialiser sends the top bytes first
  localparam int MSG_W = 40;
  localparam logic [MSG_W-1:0] MSG_CRLF = {CH_CR, CH_LF, 24'h0};
  localparam logic [MSG_W-1:0] MSG_OK   = {8'h6f, 8'h6b, CH_CR, CH_LF, 8'h00};
  localparam logic [MSG_W-1:0] MSG_RST  = {8'h72, 8'h73, 8'h74, CH_CR, CH_LF};
  localparam logic [MSG_W-1:0] MSG_ERR  = {8'h3f, CH_CR, CH_LF, 16'h0};

  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h46) ? (b | 8'h20) : b;
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic is_sp(input logic [7:0] b);
    return (b == CH_SP) || (b == CH_TAB);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic logic [3:0] hex2nib(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_dbg_txfmt.sv
// Response serialiser: optional word as hex digits (MSB first), then up to five literal bytes.
module uart_dbg_txfmt
  import uart_dbg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_hex_en,
  input  logic [DATA_W-1:0] i_word,
  input  logic [MSG_W-1:0]  i_msg,
  input  logic [2:0]        i_msg_len,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_busy
);
  localparam int NDIG = DATA_W / 4;
  localparam int DCW  = $clog2(NDIG + 1);

  logic [DATA_W-1:0] word_q, word_d;
  logic [DCW-1:0]    dig_q, dig_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [2:0]        len_q, len_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;

  always_comb begin
    word_d  = word_q;
    dig_d   = dig_q;
    msg_d   = msg_q;
    len_d   = len_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (i_load) begin
      word_d = i_word;
      dig_d  = i_hex_en ? DCW'(NDIG) : '0;
      msg_d  = i_msg;
      len_d  = i_msg_len;
    end else if (!valid_q || i_tx_ready) begin
      // Output only advances on acceptance, so data holds while stalled
      if (dig_q != '0) begin
        data_d  = nib2hex(word_q[DATA_W-1 -: 4]);
        word_d  = word_q << 4;
        dig_d   = dig_q - DCW'(1);
        valid_d = 1'b1;
      end else if (len_q != '0) begin
        data_d  = msg_q[MSG_W-1 -: 8];
        msg_d   = msg_q << 8;
        len_d   = len_q - 3'd1;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      dig_q   <= '0;
      msg_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      word_q  <= word_d;
      dig_q   <= dig_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_tx_valid = valid_q;
  assign o_tx_data  = data_q;
  assign o_busy     = valid_q || (dig_q != '0) || (len_q != '0);

endmodule

// File: rtl/uart_dbg_bridge.sv
// ASCII hex debug command parser mastering a simple read/write bus port,
// with burst reads, target reset pulse and overrun reporting.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_data,
  output logic                o_tx_valid,
  output logic [7:0]          o_tx_data,
  input  logic                i_tx_ready,
  output logic                o_rd_req,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic                i_rd_gnt,
  input  logic [DATA_W-1:0]   i_rd_data,
  output logic                o_wr_req,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_be,
  input  logic                i_wr_gnt,
  output logic                o_rst_n,
  output logic [ADDR_W-1:0]   o_boot_addr,
  output logic                o_overrun
);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, boot_q, boot_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       rcnt_q, rcnt_d;
  logic              rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic              trst_n_q, trst_n_d, ovr_q, ovr_d;

  logic              tx_load, tx_hex, tx_busy;
  logic [MSG_W-1:0]  tx_msg;
  logic [2:0]        tx_len;
  logic [7:0]        rx;
  logic [3:0]        nib;
  logic              hex, sp, eol, parsing;

  always_comb begin
    rx      = fold_case(i_rx_data);
    nib     = hex2nib(rx);
    hex     = i_rx_valid && is_hex(rx);
    sp      = i_rx_valid && is_sp(rx);
    eol     = i_rx_valid && is_eol(rx);
    parsing = state_q inside {S_IDLE, S_ADDR, S_SEP, S_DATA, S_TAIL, S_CNT, S_RCMD, S_ERR};

    state_d  = state_q;
    addr_d   = addr_q;
    boot_d   = boot_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    trst_n_d = trst_n_q;
    ovr_d    = ovr_q;
    tx_load  = 1'b0;
    tx_hex   = 1'b0;
    tx_msg   = MSG_CRLF;
    tx_len   = 3'd2;

    if (i_rx_valid && !parsing) ovr_d = 1'b1;
    else if (eol)               ovr_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hex) begin
          addr_d  = ADDR_W'(nib);
          state_d = S_ADDR;
        end else if (i_rx_valid && rx == CH_R) begin
          addr_d  = '0;
          state_d = S_RCMD;
        end else if (i_rx_valid && !sp && !eol) begin
          state_d = S_ERR;
        end
      end
      S_ADDR: begin
        if (hex)      addr_d = {addr_q[ADDR_W-5:0], nib};
        else if (sp)  state_d = S_SEP;
        else if (eol) begin
          cnt_d    = 8'd1;
          rd_req_d = 1'b1;
          state_d  = S_RD_REQ;
        end else if (i_rx_valid) state_d = S_ERR;
      end
      S_SEP: begin
        if (hex) begin
          data_d  = DATA_W'(nib);
          state_d = S_DATA;
        end else if (i_rx_valid && rx == CH_STAR) begin
          cnt_d   = '0;
          state_d = S_CNT;
        end else if (eol) begin
          cnt_d    = 8'd1;
          rd_req_d = 1'b1;
          state_d  = S_RD_REQ;
        end else if (i_rx_valid && !sp) state_d = S_ERR;
      end
      S_DATA, S_TAIL: begin
        if (hex && state_q == S_DATA) data_d = {data_q[DATA_W-5:0], nib};
        else if (sp)  state_d = S_TAIL;
        else if (eol) begin
          wr_req_d = 1'b1;
          state_d  = S_WR_REQ;
        end else if (i_rx_valid) state_d = S_ERR;
      end
      S_CNT: begin
        if (hex) cnt_d = {cnt_q[3:0], nib};
        else if (eol) begin
          if (cnt_q != 8'd0 && cnt_q <= 8'(MAX_BURST)) begin
            rd_req_d = 1'b1;
            state_d  = S_RD_REQ;
          end else begin
            tx_load = 1'b1;
            tx_msg  = MSG_ERR;
            tx_len  = 3'd3;
            state_d = S_SEND;
          end
        end else if (i_rx_valid) state_d = S_ERR;
      end
      S_RCMD: begin
        if (hex) addr_d = {addr_q[ADDR_W-5:0], nib};
        else if (eol) begin
          boot_d  = {addr_q[ADDR_W-1:2], 2'b00};
          tx_load = 1'b1;
          tx_msg  = MSG_RST;
          tx_len  = 3'd5;
          state_d = S_RST_TX;
        end else if (i_rx_valid && !sp) state_d = S_ERR;
      end
      S_ERR: begin
        if (eol) begin
          tx_load = 1'b1;
          tx_msg  = MSG_ERR;
          tx_len  = 3'd3;
          state_d = S_SEND;
        end
      end
      S_RD_REQ: begin
        if (i_rd_gnt) begin
          rd_req_d = 1'b0;
          state_d  = S_RD_CAP;
        end
      end
      S_RD_CAP: begin
        // Read data is only valid this cycle; it goes straight into the serialiser
        tx_load = 1'b1;
        tx_hex  = 1'b1;
        addr_d  = addr_q + ADDR_INC;
        cnt_d   = cnt_q - 8'd1;
        state_d = S_RD_TX;
      end
      S_RD_TX: begin
        if (!tx_busy) begin
          if (cnt_q != 8'd0) begin
            rd_req_d = 1'b1;
            state_d  = S_RD_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WR_REQ: begin
        if (i_wr_gnt) begin
          wr_req_d = 1'b0;
          tx_load  = 1'b1;
          tx_msg   = MSG_OK;
          tx_len   = 3'd4;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      S_RST_TX: begin
        if (!tx_busy) begin
          trst_n_d = 1'b0;
          rcnt_d   = 16'(RST_CYCLES - 1);
          state_d  = S_RST_PULSE;
        end
      end
      S_RST_PULSE: begin
        if (rcnt_q == 16'd0) begin
          trst_n_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          rcnt_d = rcnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      boot_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      trst_n_q <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      boot_q   <= boot_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      trst_n_q <= trst_n_d;
      ovr_q    <= ovr_d;
    end
  end

  uart_dbg_txfmt #(.DATA_W(DATA_W)) u_txfmt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (tx_load),
    .i_hex_en   (tx_hex),
    .i_word     (i_rd_data),
    .i_msg      (tx_msg),
    .i_msg_len  (tx_len),
    .i_tx_ready (i_tx_ready),
    .o_tx_valid (o_tx_valid),
    .o_tx_data  (o_tx_data),
    .o_busy     (tx_busy)
  );

  assign o_rd_req    = rd_req_q;
  assign o_rd_addr   = addr_q;
  assign o_wr_req    = wr_req_q;
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = data_q;
  assign o_wr_be     = '1;
  assign o_rst_n     = trst_n_q;
  assign o_boot_addr = boot_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Scoreboard bench for uart_dbg_bridge: stimulus queues expected bytes and bus
// cycles, a negedge monitor pops and compares whenever the DUT presents them.
module tb_uart_dbg_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready = 1'b1;
  logic        o_rd_req;
  logic [31:0] o_rd_addr;
  logic        i_rd_gnt = 1'b0;
  logic [31:0] i_rd_data = '0;
  logic        o_wr_req;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic [3:0]  o_wr_be;
  logic        i_wr_gnt = 1'b0;
  logic        o_rst_n;
  logic [31:0] o_boot_addr;
  logic        o_overrun;

  int errors = 0;
  int checks = 0;
  int gnt_delay = 0;
  bit ready_toggle = 1'b0;

  logic [7:0]  tx_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] rd_data_q[$];
  logic [63:0] wr_q[$];
  logic [31:0] boot_q[$];
  int          pulse_q[$];

  always #5 clk = ~clk;

  uart_dbg_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .RST_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_gnt(i_rd_gnt), .i_rd_data(i_rd_data),
    .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_be(o_wr_be),
    .i_wr_gnt(i_wr_gnt), .o_rst_n(o_rst_n), .o_boot_addr(o_boot_addr), .o_overrun(o_overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, required no such event", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_line(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    tx_q.push_back(8'h0d);
    tx_q.push_back(8'h0a);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_q.size() != 0 || rd_addr_q.size() != 0 || wr_q.size() != 0 ||
            pulse_q.size() != 0 || o_tx_valid) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) unexpected("wait_idle_timeout", 64'(tx_q.size()));
    tick(10);
  endtask

  task automatic rd_responder();
    int wait_n = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        i_rd_gnt = 1'b0;
        wait_n = 0;
      end else if (i_rd_gnt) begin
        i_rd_gnt  = 1'b0;
        wait_n    = 0;
        i_rd_data = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 32'h0;
      end else if (o_rd_req) begin
        if (wait_n >= gnt_delay) i_rd_gnt = 1'b1;
        else wait_n++;
      end
    end
  endtask

  task automatic wr_responder();
    int wait_n = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || i_wr_gnt) begin
        i_wr_gnt = 1'b0;
        wait_n = 0;
      end else if (o_wr_req) begin
        if (wait_n >= gnt_delay) i_wr_gnt = 1'b1;
        else wait_n++;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      i_tx_ready = ready_toggle ? ~i_tx_ready : 1'b1;
    end
  endtask

  task automatic monitor();
    bit         tx_stall = 1'b0;
    bit         rd_stall = 1'b0;
    logic [7:0] stall_data = '0;
    logic [63:0] w;
    int         low_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_stall = 1'b0;
        rd_stall = 1'b0;
        low_cnt  = 0;
      end else begin
        if (tx_stall) check("tx_hold", 64'({o_tx_valid, o_tx_data}), 64'({1'b1, stall_data}));
        tx_stall   = o_tx_valid && !i_tx_ready;
        stall_data = o_tx_data;
        if (o_tx_valid && i_tx_ready) begin
          if (tx_q.size() == 0) unexpected("tx_byte", 64'(o_tx_data));
          else check("tx_byte", 64'(o_tx_data), 64'(tx_q.pop_front()));
        end
        if (rd_stall) check("rd_req_held", 64'(o_rd_req), 64'(1));
        rd_stall = o_rd_req && !i_rd_gnt;
        if (o_rd_req && i_rd_gnt) begin
          if (rd_addr_q.size() == 0) unexpected("rd_cycle", 64'(o_rd_addr));
          else check("rd_addr", 64'(o_rd_addr), 64'(rd_addr_q.pop_front()));
        end
        if (o_wr_req && i_wr_gnt) begin
          if (wr_q.size() == 0) unexpected("wr_cycle", 64'(o_wr_addr));
          else begin
            w = wr_q.pop_front();
            check("wr_addr", 64'(o_wr_addr), 64'(w[63:32]));
            check("wr_data", 64'(o_wr_data), 64'(w[31:0]));
            check("wr_be", 64'(o_wr_be), 64'(4'hf));
          end
        end
        if (!o_rst_n) begin
          if (low_cnt == 0) check("rst_after_tx", 64'(tx_q.size()), 64'(0));
          low_cnt++;
        end else if (low_cnt != 0) begin
          if (pulse_q.size() == 0) unexpected("rst_pulse", 64'(low_cnt));
          else begin
            check("rst_len", 64'(low_cnt), 64'(pulse_q.pop_front()));
            check("boot_addr", 64'(o_boot_addr), 64'(boot_q.pop_front()));
          end
          low_cnt = 0;
        end
      end
    end
  endtask

  task automatic wait_signal(input bit wr, input string name);
    int n = 0;
    while (!(wr ? o_wr_req : o_rd_req) && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) unexpected(name, 64'(n));
  endtask

  initial begin
    fork
      rd_responder();
      wr_responder();
      ready_driver();
      monitor();
      begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
      end
    join_none

    tick(3);
    check("rst_tx_valid", 64'(o_tx_valid), 64'(0));
    check("rst_rd_req", 64'(o_rd_req), 64'(0));
    check("rst_wr_req", 64'(o_wr_req), 64'(0));
    check("rst_o_rst_n", 64'(o_rst_n), 64'(1));
    check("rst_wr_be", 64'(o_wr_be), 64'(4'hf));
    check("rst_boot", 64'(o_boot_addr), 64'(0));
    check("rst_overrun", 64'(o_overrun), 64'(0));
    check("rst_rd_addr", 64'(o_rd_addr), 64'(0));
    rst_n = 1'b1;
    tick(2);

    // single read
    rd_addr_q.push_back(32'h1000);
    rd_data_q.push_back(32'hdeadbeef);
    expect_line("deadbeef");
    send_str("1000"); send_byte(8'h0a);
    wait_idle();

    // write terminated by CR
    wr_q.push_back({32'h20, 32'h00c0ffee});
    expect_line("ok");
    send_str("20 00c0ffee"); send_byte(8'h0d);
    wait_idle();

    // burst of three with slow grants
    gnt_delay = 5;
    rd_addr_q.push_back(32'h0); rd_addr_q.push_back(32'h4); rd_addr_q.push_back(32'h8);
    rd_data_q.push_back(32'h01234567); rd_data_q.push_back(32'h89abcdef); rd_data_q.push_back(32'h000000ff);
    expect_line("01234567"); expect_line("89abcdef"); expect_line("000000ff");
    send_str("0 *3"); send_byte(8'h0a);
    wait_idle();
    gnt_delay = 0;

    // target reset with boot address
    boot_q.push_back(32'h80000000);
    pulse_q.push_back(4);
    expect_line("rst");
    send_str("r 80000003"); send_byte(8'h0a);
    wait_idle();
    check("boot_hold", 64'(o_boot_addr), 64'(32'h80000000));

    // errors: bad char, N=0, N=0x11 above MAX_BURST
    expect_line("?");
    send_str("12g"); send_byte(8'h0a);
    wait_idle();
    expect_line("?");
    send_str("0 *0"); send_byte(8'h0a);
    wait_idle();
    expect_line("?");
    send_str("0 *11"); send_byte(8'h0a);
    wait_idle();

    // upper-case hex folded
    rd_addr_q.push_back(32'h00000abc);
    rd_data_q.push_back(32'hcafef00d);
    expect_line("cafef00d");
    send_str("ABC"); send_byte(8'h0a);
    wait_idle();

    // burst crossing address wrap
    rd_addr_q.push_back(32'hfffffffc); rd_addr_q.push_back(32'h0);
    rd_data_q.push_back(32'h11111111); rd_data_q.push_back(32'h22222222);
    expect_line("11111111"); expect_line("22222222");
    send_str("fffffffc *2"); send_byte(8'h0a);
    wait_idle();

    // byte dropped while busy, throttled tx
    ready_toggle = 1'b1;
    gnt_delay = 3;
    rd_addr_q.push_back(32'h40); rd_addr_q.push_back(32'h44);
    rd_data_q.push_back(32'h5a5a0f0f); rd_data_q.push_back(32'h76543210);
    expect_line("5a5a0f0f"); expect_line("76543210");
    send_str("40 *2"); send_byte(8'h0a);
    wait_signal(1'b0, "rd_req_timeout");
    send_byte(8'h78);
    wait_idle();
    check("overrun_set", 64'(o_overrun), 64'(1));
    ready_toggle = 1'b0;
    gnt_delay = 0;
    tick(2);
    send_byte(8'h0a);
    tick(3);
    check("overrun_clr", 64'(o_overrun), 64'(0));

    // reset while a write request is pending: cycle must not complete
    gnt_delay = 20;
    send_str("30 5"); send_byte(8'h0a);
    wait_signal(1'b1, "wr_req_timeout");
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("abort_wr_req", 64'(o_wr_req), 64'(0));
    check("abort_tx", 64'(o_tx_valid), 64'(0));
    rst_n = 1'b1;
    send_byte(8'h0a);
    tick(40);
    gnt_delay = 0;
    check("abort_no_req", 64'({o_wr_req, o_rd_req}), 64'(0));

    // partial command aborted by reset
    send_str("5 12");
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    send_byte(8'h0a);
    tick(20);
    check("leftover_tx", 64'(tx_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
